prog_rom_loader: RTL and testbench

Program memory and loader for the TD4 core: a 16 x 8-bit writable instruction store that sits directly upstream of the decoder and ALU input selector. It supplies the instruction word addressed by the program counter (opcode in bits 7:4 to the decoder, immediate in bits 3:0 to the adder) and gates CPU execution. It accepts a 16-byte program through a byte-wide valid/ready load port and releases the core only after a complete load or an explicit run request.

---
 rtl/prog_rom_loader.sv | 129 ++++++++++++
 tb/tb_prog_rom_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_rom_loader.sv
// Program memory and byte-wide loader for the TD4 core.
// Holds 16 instruction words, fills them over a valid/ready port and gates core execution.
module prog_rom_loader #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic                run_req,
   input  logic                load_valid,
   input  logic [DATA_W-1:0]   load_data,
   output logic                load_ready,
   output logic [ADDR_W:0]     load_count,
   output logic [DATA_W-1:0]   checksum,
   output logic                load_done,
   input  logic [ADDR_W-1:0]   pc_addr,
   output logic [DATA_W-1:0]   instr,
   output logic                cpu_run
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_nx;
   logic [CNT_W-1:0]    count_nx;
   logic [DATA_W-1:0]   sum_nx;
   logic                ready_nx;
   logic                run_nx;
   logic                done_nx;
   logic                wr_en;

   // A restart in the same cycle as a transfer discards the byte.
   assign wr_en = (state == S_LOAD) && load_valid && load_ready && !load_start;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (load_start) begin
               state_nx = S_LOAD;
            end else if (run_req) begin
               state_nx = S_RUN;
            end
         end
         S_LOAD: begin
            if (wr_en && (ptr == LAST_ADDR)) begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (load_start) begin
               state_nx = S_LOAD;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Next values for the registered outputs and the load bookkeeping.
   always_comb begin
      ready_nx = (state_nx == S_LOAD);
      run_nx   = (state_nx == S_RUN);
      done_nx  = wr_en && (ptr == LAST_ADDR);
      ptr_nx   = ptr;
      count_nx = load_count;
      sum_nx   = checksum;
      if (load_start) begin
         ptr_nx   = '0;
         count_nx = '0;
         sum_nx   = '0;
      end else if (wr_en) begin
         ptr_nx   = ptr + ADDR_W'(1);
         count_nx = load_count + CNT_W'(1);
         sum_nx   = checksum + load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr        <= '0;
         load_count <= '0;
         checksum   <= '0;
         load_ready <= 1'b0;
         cpu_run    <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         ptr        <= ptr_nx;
         load_count <= count_nx;
         checksum   <= sum_nx;
         load_ready <= ready_nx;
         cpu_run    <= run_nx;
         load_done  <= done_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[ptr] <= load_data;
      end
   end

   // Zero-latency fetch; the core only sees real words while released.
   assign instr = (state == S_RUN) ? mem[pc_addr] : '0;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed self-checking bench for prog_rom_loader.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_prog_rom_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_start;
   logic       run_req;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [4:0] load_count;
   logic [7:0] checksum;
   logic       load_done;
   logic [3:0] pc_addr;
   logic [7:0] instr;
   logic       cpu_run;

   int vecs = 0;
   int errs = 0;

   prog_rom_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .run_req    (run_req),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_count (load_count),
      .checksum   (checksum),
      .load_done  (load_done),
      .pc_addr    (pc_addr),
      .instr      (instr),
      .cpu_run    (cpu_run)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      load_start = 1'b0;
      run_req = 1'b0;
      load_valid = 1'b0;
      load_data = 8'h00;
      pc_addr = 4'h0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Drives 16 consecutive transfers of base + i*step; checks live in the tests.
   task automatic push16(input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data = base + 8'(i) * step;
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (load_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", load_ready); end
      vecs++; if (cpu_run !== 1'b0) begin errs++; $display("FAIL reset_run got %b exp 0", cpu_run); end
      vecs++; if (load_count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", load_count); end
      vecs++; if (checksum !== 8'h00) begin errs++; $display("FAIL reset_sum got %h exp 00", checksum); end
      vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", load_done); end
      vecs++; if (instr !== 8'h00) begin errs++; $display("FAIL reset_instr got %h exp 00", instr); end
   endtask

   task automatic test_back_to_back();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      vecs++; if (load_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_rise got %b exp 1", load_ready); end
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data = 8'h30 + 8'(i);
         tick();
         if (i < 15) begin
            vecs++; if (load_done !== 1'b0 || cpu_run !== 1'b0 || load_count !== 5'(i + 1)) begin
               errs++; $display("FAIL b2b_progress i=%0d done=%b run=%b count=%0d exp 0 0 %0d", i, load_done, cpu_run, load_count, i + 1);
            end
         end
      end
      load_valid = 1'b0;
      vecs++; if (load_done !== 1'b1) begin errs++; $display("FAIL b2b_done got %b exp 1", load_done); end
      vecs++; if (cpu_run !== 1'b1) begin errs++; $display("FAIL b2b_run got %b exp 1", cpu_run); end
      vecs++; if (load_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_fall got %b exp 0", load_ready); end
      vecs++; if (load_count !== 5'd16) begin errs++; $display("FAIL b2b_count got %0d exp 16", load_count); end
      vecs++; if (checksum !== 8'h78) begin errs++; $display("FAIL b2b_sum got %h exp 78", checksum); end
      tick();
      vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL b2b_done_pulse got %b exp 0", load_done); end
      for (int a = 0; a < 16; a++) begin
         pc_addr = 4'(a);
         #1;
         vecs++; if (instr !== 8'h30 + 8'(a)) begin errs++; $display("FAIL b2b_instr a=%0d got %h exp %h", a, instr, 8'h30 + 8'(a)); end
      end
   endtask

   task automatic test_stall();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int c = 0; c < 32; c++) begin
         if (c % 2 == 1) begin
            load_valid = 1'b1;
            load_data = 8'h11 * 8'(c / 2);
         end else begin
            load_valid = 1'b0;
            load_data = 8'hFF;
         end
         tick();
         if (c < 31) begin
            vecs++; if (load_ready !== 1'b1 || cpu_run !== 1'b0 || load_count !== 5'((c + 1) / 2)) begin
               errs++; $display("FAIL stall_progress c=%0d ready=%b run=%b count=%0d exp 1 0 %0d", c, load_ready, cpu_run, load_count, (c + 1) / 2);
            end
         end
      end
      load_valid = 1'b0;
      vecs++; if (load_done !== 1'b1 || cpu_run !== 1'b1) begin errs++; $display("FAIL stall_done done=%b run=%b exp 1 1", load_done, cpu_run); end
      vecs++; if (checksum !== 8'hF8) begin errs++; $display("FAIL stall_sum got %h exp f8", checksum); end
      for (int a = 0; a < 16; a++) begin
         pc_addr = 4'(a);
         #1;
         vecs++; if (instr !== 8'h11 * 8'(a)) begin errs++; $display("FAIL stall_instr a=%0d got %h exp %h", a, instr, 8'h11 * 8'(a)); end
      end
   endtask

   task automatic test_restart();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      vecs++; if (cpu_run !== 1'b0 || load_ready !== 1'b1 || instr !== 8'h00) begin
         errs++; $display("FAIL run_to_load run=%b ready=%b instr=%h exp 0 1 00", cpu_run, load_ready, instr);
      end
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data = 8'hC0 + 8'(i);
         tick();
      end
      vecs++; if (load_count !== 5'd5) begin errs++; $display("FAIL restart_pre_count got %0d exp 5", load_count); end
      load_start = 1'b1;
      load_data = 8'hEE;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      vecs++; if (load_count !== 5'd0 || checksum !== 8'h00 || load_ready !== 1'b1) begin
         errs++; $display("FAIL restart_clear count=%0d sum=%h ready=%b exp 0 00 1", load_count, checksum, load_ready);
      end
      run_req = 1'b1;
      tick();
      tick();
      run_req = 1'b0;
      vecs++; if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin errs++; $display("FAIL restart_runreq run=%b ready=%b exp 0 1", cpu_run, load_ready); end
      push16(8'hA5, 8'h00);
      vecs++; if (load_count !== 5'd16 || checksum !== 8'h50 || cpu_run !== 1'b1) begin
         errs++; $display("FAIL restart_final count=%0d sum=%h run=%b exp 16 50 1", load_count, checksum, cpu_run);
      end
      pc_addr = 4'd5;
      #1;
      vecs++; if (instr !== 8'hA5) begin errs++; $display("FAIL restart_instr got %h exp a5", instr); end
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      push16(8'h00, 8'h00);
      do_reset();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         load_valid = 1'b1;
         load_data = 8'h70 + 8'(i);
         tick();
      end
      load_valid = 1'b0;
      rst = 1'b0;
      run_req = 1'b1;
      tick();
      vecs++; if (load_ready !== 1'b0 || cpu_run !== 1'b0 || load_count !== 5'd0) begin
         errs++; $display("FAIL midrst_state ready=%b run=%b count=%0d exp 0 0 0", load_ready, cpu_run, load_count);
      end
      tick();
      vecs++; if (cpu_run !== 1'b0) begin errs++; $display("FAIL midrst_hold run=%b exp 0", cpu_run); end
      rst = 1'b1;
      tick();
      run_req = 1'b0;
      vecs++; if (cpu_run !== 1'b1) begin errs++; $display("FAIL midrst_run got %b exp 1", cpu_run); end
      for (int a = 0; a < 16; a++) begin
         pc_addr = 4'(a);
         #1;
         vecs++; if (instr !== 8'h00) begin errs++; $display("FAIL midrst_instr a=%0d got %h exp 00", a, instr); end
      end
   endtask

   task automatic test_priority_reload();
      do_reset();
      load_start = 1'b1;
      run_req = 1'b1;
      tick();
      load_start = 1'b0;
      vecs++; if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin errs++; $display("FAIL prio ready=%b run=%b exp 1 0", load_ready, cpu_run); end
      tick();
      run_req = 1'b0;
      vecs++; if (cpu_run !== 1'b0) begin errs++; $display("FAIL prio_hold run=%b exp 0", cpu_run); end
      push16(8'h00, 8'h03);
      vecs++; if (checksum !== 8'h68 || cpu_run !== 1'b1) begin errs++; $display("FAIL prio_load sum=%h run=%b exp 68 1", checksum, cpu_run); end
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      vecs++; if (cpu_run !== 1'b0 || load_ready !== 1'b1 || instr !== 8'h00 || checksum !== 8'h00) begin
         errs++; $display("FAIL reload_enter run=%b ready=%b instr=%h sum=%h exp 0 1 00 00", cpu_run, load_ready, instr, checksum);
      end
      push16(8'hF0, 8'h01);
      vecs++; if (cpu_run !== 1'b1 || load_done !== 1'b1 || checksum !== 8'h78) begin
         errs++; $display("FAIL reload_done run=%b done=%b sum=%h exp 1 1 78", cpu_run, load_done, checksum);
      end
      pc_addr = 4'd15;
      #1;
      vecs++; if (instr !== 8'hFF) begin errs++; $display("FAIL reload_instr got %h exp ff", instr); end
      tick();
      tick();
      vecs++; if (checksum !== 8'h78 || load_count !== 5'd16) begin errs++; $display("FAIL hold_in_run sum=%h count=%0d exp 78 16", checksum, load_count); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_restart();
      test_reset_mid_load();
      test_priority_reload();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
